// File: rtl/carrier_gen_multimode.sv
// Multi-mode PWM carrier generator: triangle / sawtooth-up / sawtooth-down counter with prescaler and shadowed peak/mode.
// Latency: carrier and flags are registered; a tick or sync_in is reflected one clock later.
// Backpressure: none; enable=0 freezes all state, and sync_in acts regardless of enable.
//
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   enable             - advance prescaler/counter when 1
//   divider            - tick every divider+1 clocks
//   carrier_max, mode  - shadow inputs, copied to active registers at the load point
//   update_sel         - load point: 00 every tick, 01 valley, 10 peak, 11 both
//   sync_in            - resync strobe: reload active registers, carrier <= min(phase_offset, carrier_max)
//   phase_offset       - count loaded by sync_in
//   carrier            - registered count
//   carrier_high/low   - count at active_max / at zero
//   dir                - 1 counting up, 0 counting down
//   load_pulse         - one clock after active registers were reloaded
module carrier_gen_multimode #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] divider,
  input  logic [CNT_W-1:0] carrier_max,
  input  logic [1:0]       mode,
  input  logic [1:0]       update_sel,
  input  logic             sync_in,
  input  logic [CNT_W-1:0] phase_offset,
  output logic [CNT_W-1:0] carrier,
  output logic             carrier_high,
  output logic             carrier_low,
  output logic             dir,
  output logic             load_pulse
);

  localparam logic [1:0] MODE_TRI = 2'b00;
  localparam logic [1:0] MODE_UP  = 2'b01;
  localparam logic [1:0] MODE_DN  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [DIV_W-1:0] prescaler;
  logic [CNT_W-1:0] active_max;
  logic [1:0]       active_mode;

  logic             tick;
  logic             valley;
  logic             peak;
  logic             load_pt;
  logic [1:0]       mode_norm;
  logic [CNT_W-1:0] nxt_max;
  logic [1:0]       nxt_mode;
  logic             dir_eff;
  logic [CNT_W-1:0] nxt_cnt;
  logic             nxt_dir;
  logic [CNT_W-1:0] sync_cnt;

  assign tick   = enable && (prescaler == divider);
  assign valley = (carrier == '0);
  assign peak   = (carrier == active_max);

  // Reserved mode encoding is stored as triangle so the active register only ever holds legal modes.
  assign mode_norm = (mode == 2'b11) ? MODE_TRI : mode;

  always_comb begin
    load_pt = 1'b0;
    case (update_sel)
      2'b00:   load_pt = 1'b1;
      2'b01:   load_pt = valley;
      2'b10:   load_pt = peak;
      default: load_pt = valley || peak;
    endcase
  end

  // The count step on a loading tick already uses the freshly loaded shadow values.
  assign nxt_max  = load_pt ? carrier_max : active_max;
  assign nxt_mode = load_pt ? mode_norm   : active_mode;

  // Sawtooth modes pin the direction; triangle inherits whatever it was.
  assign dir_eff = (nxt_mode == MODE_UP) ? 1'b1 :
                   (nxt_mode == MODE_DN) ? 1'b0 : dir;

  always_comb begin
    nxt_cnt = carrier;
    nxt_dir = dir_eff;
    if (nxt_max == '0) begin
      nxt_cnt = '0;
    end else if (carrier > nxt_max) begin
      // Peak shrank below the current count: snap back into range.
      if (nxt_mode == MODE_UP) begin
        nxt_cnt = '0;
      end else begin
        nxt_cnt = nxt_max;
        nxt_dir = 1'b0;
      end
    end else begin
      case (nxt_mode)
        MODE_UP: nxt_cnt = (carrier == nxt_max) ? '0 : carrier + CNT_ONE;
        MODE_DN: nxt_cnt = (carrier == '0) ? nxt_max : carrier - CNT_ONE;
        default: begin
          if (dir_eff) begin
            if (carrier == nxt_max) begin
              nxt_dir = 1'b0;
              nxt_cnt = nxt_max - CNT_ONE;
            end else begin
              nxt_cnt = carrier + CNT_ONE;
            end
          end else begin
            if (carrier == '0) begin
              nxt_dir = 1'b1;
              nxt_cnt = CNT_ONE;
            end else begin
              nxt_cnt = carrier - CNT_ONE;
            end
          end
        end
      endcase
    end
  end

  assign sync_cnt = (phase_offset > carrier_max) ? carrier_max : phase_offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler   <= '0;
      carrier     <= '0;
      dir         <= 1'b1;
      active_max  <= '0;
      active_mode <= MODE_TRI;
      load_pulse  <= 1'b0;
    end else if (sync_in) begin
      prescaler   <= '0;
      active_max  <= carrier_max;
      active_mode <= mode_norm;
      carrier     <= sync_cnt;
      dir         <= (mode_norm != MODE_DN);
      load_pulse  <= 1'b1;
    end else begin
      load_pulse <= 1'b0;
      if (enable) begin
        prescaler <= tick ? '0 : prescaler + DIV_ONE;
      end
      if (tick) begin
        carrier     <= nxt_cnt;
        dir         <= nxt_dir;
        active_max  <= nxt_max;
        active_mode <= nxt_mode;
        load_pulse  <= load_pt;
      end
    end
  end

  assign carrier_high = (carrier == active_max);
  assign carrier_low  = (carrier == '0);

endmodule

// File: doc/carrier_gen_multimode.md
CARRIER_GEN_MULTIMODE -- requirements
Module: carrier_gen_multimode

Interface
REQ-001 Parameter CNT_W, default 16, carrier counter and carrier_max width.
REQ-002 Parameter DIV_W, default 8, prescaler divider width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 enable  in  1  1 = prescaler and counter advance; 0 = all state holds.
REQ-006 divider  in  DIV_W  tick every divider+1 clocks; 0 = tick every clock.
REQ-007 carrier_max  in  CNT_W  requested peak value (shadow input).
REQ-008 mode  in  2  requested waveform: 00 triangle, 01 sawtooth-up, 10 sawtooth-down, 11 reserved = triangle.
REQ-009 update_sel  in  2  shadow-load point: 00 every tick, 01 valley, 10 peak, 11 valley and peak.
REQ-010 sync_in  in  1  synchronous resync strobe.
REQ-011 phase_offset  in  CNT_W  count value loaded on sync_in.
REQ-012 carrier  out  CNT_W  registered carrier count.
REQ-013 carrier_high  out  1  1 while carrier == active_max.
REQ-014 carrier_low  out  1  1 while carrier == 0.
REQ-015 dir  out  1  1 = counting up, 0 = counting down.
REQ-016 load_pulse  out  1  one-clock pulse on the edge active_max/active_mode are reloaded.

Function
REQ-017 Prescaler: counter 0..divider; tick asserted on the clock where prescaler == divider and enable == 1, prescaler then returns to 0.
REQ-018 Counter, active_max, active_mode, dir change only on tick or sync_in.
REQ-019 Triangle: up by 1 per tick; at active_max with dir=1 -> dir=0, count=active_max-1; at 0 with dir=0 -> dir=1, count=1; period 2*active_max ticks.
REQ-020 Sawtooth-up: up by 1 per tick; active_max -> 0; dir constant 1; period active_max+1 ticks.
REQ-021 Sawtooth-down: down by 1 per tick; 0 -> active_max; dir constant 0; period active_max+1 ticks.
REQ-022 Valley = tick with carrier == 0; peak = tick with carrier == active_max.
REQ-023 On tick at a selected load point (per update_sel), active_max <= carrier_max, active_mode <= mode, load_pulse = 1 next cycle.
REQ-024 Next count on a loading tick is computed from the newly loaded active_max/active_mode.
REQ-025 Out-of-range: if carrier > active_max on a tick, next count = active_max (triangle, sawtooth-down, dir=0) or 0 (sawtooth-up).
REQ-026 Mode change into sawtooth-up forces dir=1; into sawtooth-down forces dir=0; into triangle keeps dir.
REQ-027 active_max == 0: carrier holds 0, carrier_high = carrier_low = 1, no error.
REQ-028 sync_in = 1 (any enable): active registers load from inputs, carrier <= min(phase_offset, new active_max), dir <= 1 (0 for sawtooth-down), prescaler <= 0, load_pulse = 1.
REQ-029 sync_in has priority over tick in the same cycle.
REQ-030 carrier_high, carrier_low, dir are functions of registered state only; no input-to-output combinational path.

Reset
REQ-031 rst_n = 0 immediately forces carrier=0, dir=1, prescaler=0, active_max=0, active_mode=triangle, load_pulse=0.
REQ-032 During and right after reset carrier_high=1, carrier_low=1 (active_max=0).
REQ-033 First tick after reset is both valley and peak, so active registers load for any update_sel.
REQ-034 Reset asserted mid-ramp returns to REQ-031 values within the same cycle, independent of clk.

Verification
REQ-035 divider=4, carrier_max=100, triangle, update_sel=01: carrier reaches 100 ~500 clocks after first tick, returns to 0 at ~1000; high/low each 5 clocks wide.
REQ-036 divider=0, carrier_max=9, sawtooth-up: carrier 0..9,0 repeating, period 10 clocks; sawtooth-down 9..0,9.
REQ-037 triangle max=100, update_sel=01, change carrier_max to 50 at count 40 up: peak stays 100, next ramp peaks at 50, load_pulse once at valley.
REQ-038 sync_in pulse with phase_offset=30, max=100: carrier=30, dir=1 next clock; phase_offset=200 -> carrier=100.
REQ-039 enable=0 for 20 clocks mid-ramp: carrier, dir, prescaler frozen; resume continues identically.
REQ-040 Reset mid-ramp at count 57 -> carrier=0 asynchronously; carrier_max=0 -> carrier stays 0, high=low=1.
